// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-addressed memory array.
// Handles byte/halfword/word(/doubleword) accesses with little-endian lane
// selection, optional wait states, and a two-cycle ERROR response for
// oversized, misaligned or out-of-window transfers.
module ahb_slave_mem #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       MEM_DEPTH   = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP
);

    localparam int unsigned       NB            = DATA_W / 8;
    localparam int unsigned       OFF_W         = $clog2(NB);
    localparam int unsigned       IDX_W         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]        MAX_SIZE      = 3'(OFF_W);
    localparam logic [ADDR_W:0]   WINDOW_BYTES  = (ADDR_W + 1)'(MEM_DEPTH * NB);
    localparam logic [3:0]        WAIT_CNT_INIT = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;
    localparam logic [1:0]        RESP_OKAY     = 2'b00;
    localparam logic [1:0]        RESP_ERROR    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte lanes touched by a transfer of 2^size bytes starting at lane 'off'.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        int lo;
        int n;
        m  = '0;
        lo = 32'(off);
        n  = 32'd1 << size;
        for (int b = 0; b < NB; b++) begin
            if ((b >= lo) && (b < lo + n)) begin
                m[b] = 1'b1;
            end else begin
                m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    // True when the address is not a multiple of the transfer size.
    function automatic logic misaligned(input logic [2:0] size, input logic [ADDR_W-1:0] addr);
        logic r;
        case (size)
            3'd0:    r = 1'b0;
            3'd1:    r = addr[0];
            3'd2:    r = |addr[1:0];
            3'd3:    r = |addr[2:0];
            default: r = 1'b0;  // larger sizes are rejected by the size check
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [2:0]          hsize_q, hsize_d;
    logic                hreadyout_q, hreadyout_d;
    logic [1:0]          hresp_q, hresp_d;

    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_W-1:0]   addr_off_s;
    logic                xfer_err_s;
    logic                can_accept_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   off_q_s;
    logic [IDX_W-1:0]    idx_s;
    logic [NB-1:0]       lane_s;
    logic                mem_we_s;
    logic                rd_phase_s;
    logic [DATA_W-1:0]   hrdata_s;
    logic                unused_bits_s;

    // Classify the address phase currently on the bus as legal or erroneous.
    always_comb begin
        addr_off_s = HADDR - BASE_ADDR;
        xfer_err_s = (HSIZE > MAX_SIZE)
                   | misaligned(HSIZE, HADDR)
                   | (HADDR < BASE_ADDR)
                   | ({1'b0, addr_off_s} >= WINDOW_BYTES);
    end

    // A new address phase may only start while the slave itself is ready.
    always_comb begin
        can_accept_s = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
        accept_s     = can_accept_s && HSEL && HREADY && HTRANS[1];
    end

    // State, wait counter and output register bank.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Next-state and wait-count logic; ready states pipeline a new transfer directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    if (xfer_err_s) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES != 32'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_INIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Capture the control of an accepted address phase for its data phase.
    always_comb begin
        if (accept_s) begin
            haddr_d  = HADDR;
            hwrite_d = HWRITE;
            hsize_d  = HSIZE;
        end else begin
            haddr_d  = haddr_q;
            hwrite_d = hwrite_q;
            hsize_d  = hsize_q;
        end
    end

    // Handshake outputs decoded from the upcoming state so they leave a flop.
    always_comb begin
        case (state_d)
            ST_WAIT: begin
                hreadyout_d = 1'b0;
                hresp_d     = RESP_OKAY;
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = RESP_ERROR;
            end
            ST_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
            end
        endcase
    end

    // Word index and byte lanes of the transfer in its data phase.
    always_comb begin
        off_q_s  = haddr_q - BASE_ADDR;
        idx_s    = off_q_s[IDX_W+OFF_W-1:OFF_W];
        lane_s   = lane_mask(hsize_q, off_q_s[OFF_W-1:0]);
        mem_we_s = (state_q == ST_DATA) && hwrite_q && !HRESET;
    end

    // Byte-lane write at the edge closing a write data phase; no reset so contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_s[b]) begin
                    mem_q[idx_s][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    // Full addressed word during a read data phase, zero otherwise.
    always_comb begin
        rd_phase_s = ((state_q == ST_WAIT) || (state_q == ST_DATA)) && !hwrite_q;
        if (rd_phase_s) begin
            hrdata_s = mem_q[idx_s];
        end else begin
            hrdata_s = '0;
        end
    end

    assign HRDATA    = hrdata_s;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    // Burst type, HTRANS[0] and address bits above the window carry no meaning here.
    assign unused_bits_s = ^{HBURST, HTRANS[0], off_q_s[ADDR_W-1:IDX_W+OFF_W]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: three instances (32-bit with one wait
// state, 32-bit zero-wait, 64-bit with one wait state) on a shared bus.
module tb_ahb_slave_mem;

    logic        clk;
    logic        hrst;
    logic [2:0]  hsel;
    logic        hready;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] haddr;
    logic [63:0] hwdata;

    logic        ro_a, ro_b, ro_c;
    logic [1:0]  resp_a, resp_b, resp_c;
    logic [31:0] rd_a, rd_b;
    logic [63:0] rd_c;
    logic [2:0]  ro_all;

    typedef struct {
        int          inst;
        bit          wr;
        bit          err;
        logic [63:0] rd;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          low_cnt;
    logic [1:0]  low_resp;
    int          tests;
    int          fails;

    ahb_slave_mem #(.DATA_W(32), .WAIT_STATES(1)) u_a (
        .HCLK(clk), .HRESET(hrst), .HSEL(hsel[0]), .HREADY(hready), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HADDR(haddr), .HWDATA(hwdata[31:0]),
        .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(resp_a)
    );

    ahb_slave_mem #(.DATA_W(32), .WAIT_STATES(0)) u_b (
        .HCLK(clk), .HRESET(hrst), .HSEL(hsel[1]), .HREADY(hready), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HADDR(haddr), .HWDATA(hwdata[31:0]),
        .HRDATA(rd_b), .HREADYOUT(ro_b), .HRESP(resp_b)
    );

    ahb_slave_mem #(.DATA_W(64), .WAIT_STATES(1)) u_c (
        .HCLK(clk), .HRESET(hrst), .HSEL(hsel[2]), .HREADY(hready), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(rd_c), .HREADYOUT(ro_c), .HRESP(resp_c)
    );

    assign ro_all = {ro_c, ro_b, ro_a};
    assign hready = &ro_all;

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] rd_of(input int i);
        if (i == 0) return {32'd0, rd_a};
        else if (i == 1) return {32'd0, rd_b};
        else return rd_c;
    endfunction

    function automatic logic [1:0] resp_of(input int i);
        if (i == 0) return resp_a;
        else if (i == 1) return resp_b;
        else return resp_c;
    endfunction

    function automatic int ws_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one address phase, hold it until accepted, then supply its write data.
    task automatic issue(input int inst, input bit wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rd, input bit exp_err,
                         input string tag);
        exp_t e;
        bit   acc;
        int   n;
        hsel       = 3'b000;
        hsel[inst] = 1'b1;
        htrans     = 2'b10;
        hwrite     = wr;
        hsize      = size;
        haddr      = addr;
        acc        = 1'b0;
        n          = 0;
        do begin
            #1;
            acc = hready;
            @(posedge clk);
            n++;
        end while (!acc && n < 20);
        #1;
        check_val({tag, "_accept"}, 64'(acc), 64'd1);
        if (acc) begin
            e.inst = inst;
            e.wr   = wr;
            e.err  = exp_err;
            e.rd   = exp_rd;
            e.tag  = tag;
            exp_q.push_back(e);
        end
        hsel   = 3'b000;
        htrans = 2'b00;
        hwdata = wdata;
    endtask

    // Wait for every outstanding data phase to complete.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Data-phase monitor: counts low-ready cycles, then scores the completing beat.
    always @(negedge clk) begin
        if (!hrst && exp_q.size() > 0) begin
            mon_e = exp_q[0];
            if (ro_all[mon_e.inst] == 1'b0) begin
                low_cnt++;
                low_resp = resp_of(mon_e.inst);
                if (low_cnt > 20) begin
                    check_val({mon_e.tag, "_timeout"}, 64'(low_cnt), 64'd1);
                    void'(exp_q.pop_front());
                    low_cnt = 0;
                end
            end else begin
                check_val({mon_e.tag, "_resp"}, 64'(resp_of(mon_e.inst)), mon_e.err ? 64'd1 : 64'd0);
                check_val({mon_e.tag, "_waits"}, 64'(low_cnt), mon_e.err ? 64'd1 : 64'(ws_of(mon_e.inst)));
                if (mon_e.err) begin
                    check_val({mon_e.tag, "_err1resp"}, 64'(low_resp), 64'd1);
                end
                check_val({mon_e.tag, "_rdata"}, rd_of(mon_e.inst), (mon_e.wr || mon_e.err) ? 64'd0 : mon_e.rd);
                void'(exp_q.pop_front());
                low_cnt = 0;
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        low_cnt  = 0;
        low_resp = 2'b00;
        hrst     = 1'b1;
        hsel     = 3'b000;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 3'd0;
        hburst   = 3'd0;
        haddr    = 32'd0;
        hwdata   = 64'd0;

        #12;
        check_val("rst_ready", 64'(ro_all), 64'h7);
        check_val("rst_resp", 64'({resp_c, resp_b, resp_a}), 64'd0);
        check_val("rst_rdata_a", 64'(rd_a), 64'd0);
        check_val("rst_rdata_c", rd_c, 64'd0);
        @(negedge clk);
        hrst = 1'b0;

        // Word write/read with one wait state, then byte and halfword lane merges.
        issue(0, 1'b1, 3'd2, 32'h10, 64'hDEADBEEF, 64'd0, 1'b0, "w10");
        issue(0, 1'b0, 3'd2, 32'h10, 64'd0, 64'hDEADBEEF, 1'b0, "r10");
        issue(0, 1'b1, 3'd2, 32'h10, 64'h11223344, 64'd0, 1'b0, "w10b");
        issue(0, 1'b1, 3'd0, 32'h13, 64'hAAAAAAAA, 64'd0, 1'b0, "wbyte13");
        issue(0, 1'b0, 3'd2, 32'h10, 64'd0, 64'hAA223344, 1'b0, "rbyte13");
        issue(0, 1'b1, 3'd2, 32'h14, 64'h55667788, 64'd0, 1'b0, "w14");
        issue(0, 1'b1, 3'd1, 32'h16, 64'hBEEFBEEF, 64'd0, 1'b0, "whalf16");
        issue(0, 1'b0, 3'd2, 32'h14, 64'd0, 64'hBEEF7788, 1'b0, "rhalf16");
        issue(0, 1'b1, 3'd2, 32'h3FC, 64'hA5A55A5A, 64'd0, 1'b0, "wlast");
        issue(0, 1'b0, 3'd2, 32'h3FC, 64'd0, 64'hA5A55A5A, 1'b0, "rlast");

        // Error responses must not disturb the array.
        issue(0, 1'b1, 3'd2, 32'h00, 64'h00000000, 64'd0, 1'b0, "w00");
        issue(0, 1'b1, 3'd1, 32'h01, 64'hFFFFFFFF, 64'd0, 1'b1, "whalf_mis");
        issue(0, 1'b0, 3'd2, 32'h400, 64'd0, 64'd0, 1'b1, "r_oor");
        issue(0, 1'b1, 3'd2, 32'h400, 64'hFFFFFFFF, 64'd0, 1'b1, "w_oor");
        issue(0, 1'b1, 3'd3, 32'h18, 64'hFFFFFFFF, 64'd0, 1'b1, "w_size3");
        issue(0, 1'b1, 3'd2, 32'h12, 64'hFFFFFFFF, 64'd0, 1'b1, "w_word_mis");
        issue(0, 1'b0, 3'd2, 32'h00, 64'd0, 64'h00000000, 1'b0, "r00_after_err");
        issue(0, 1'b0, 3'd2, 32'h10, 64'd0, 64'hAA223344, 1'b0, "r10_after_err");

        // Reset during the wait state of a write aborts it.
        issue(0, 1'b1, 3'd2, 32'h30, 64'h12345678, 64'd0, 1'b0, "w30");
        issue(0, 1'b0, 3'd2, 32'h30, 64'd0, 64'h12345678, 1'b0, "r30");
        drain();
        hsel   = 3'b001;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = 32'h30;
        @(posedge clk);
        #1;
        hsel   = 3'b000;
        htrans = 2'b00;
        hwdata = 64'h99990000;
        @(negedge clk);
        check_val("rst_mid_wait_ready", 64'(ro_a), 64'd0);
        #1;
        hrst = 1'b1;
        #1;
        check_val("rst_mid_ready", 64'(ro_a), 64'd1);
        check_val("rst_mid_resp", 64'(resp_a), 64'd0);
        check_val("rst_mid_rdata", 64'(rd_a), 64'd0);
        @(posedge clk);
        @(negedge clk);
        hrst = 1'b0;
        issue(0, 1'b0, 3'd2, 32'h30, 64'd0, 64'h12345678, 1'b0, "r30_after_rst");

        // Zero-wait instance: back-to-back write then read of the same word.
        issue(1, 1'b1, 3'd2, 32'h20, 64'hCAFEF00D, 64'd0, 1'b0, "b_w20");
        issue(1, 1'b0, 3'd2, 32'h20, 64'd0, 64'hCAFEF00D, 1'b0, "b_r20");
        issue(1, 1'b1, 3'd0, 32'h21, 64'h77777777, 64'd0, 1'b0, "b_wbyte21");
        issue(1, 1'b0, 3'd2, 32'h20, 64'd0, 64'hCAFE770D, 1'b0, "b_r20b");
        issue(1, 1'b0, 3'd1, 32'h23, 64'd0, 64'd0, 1'b1, "b_rhalf_mis");

        // 64-bit instance: doubleword access, upper-lane word write, oversized error.
        issue(2, 1'b1, 3'd3, 32'h08, 64'h0123456789ABCDEF, 64'd0, 1'b0, "c_w08");
        issue(2, 1'b0, 3'd3, 32'h08, 64'd0, 64'h0123456789ABCDEF, 1'b0, "c_r08");
        issue(2, 1'b1, 3'd2, 32'h0C, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b0, "c_w0c");
        issue(2, 1'b0, 3'd3, 32'h08, 64'd0, 64'hDEADBEEF89ABCDEF, 1'b0, "c_r08b");
        issue(2, 1'b0, 3'd2, 32'h0C, 64'd0, 64'hDEADBEEF89ABCDEF, 1'b0, "c_r0c");
        issue(2, 1'b0, 3'd4, 32'h10, 64'd0, 64'd0, 1'b1, "c_size4");
        issue(2, 1'b1, 3'd3, 32'h800, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, "c_w_oor");
        issue(2, 1'b0, 3'd3, 32'h08, 64'd0, 64'hDEADBEEF89ABCDEF, 1'b0, "c_r08_after_err");
        drain();

        check_val("idle_rdata", rd_c, 64'd0);
        check_val("idle_ready", 64'(ro_all), 64'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
